pc_stack_unit: RTL and testbench
================================

// Module: pc_stack_unit
// PURPOSE
//  Program-counter stage feeding instruction memory; consumes decoder controls (Jump, Branch,
//  Stack_Enable, Stack_Write, Halt) and selects next PC. Holds hardware return-address stack
//  for JAL/RET, plus HALT/fault state machine. Sits upstream of instruction ROM, downstream of decoder/ALU.
// PARAMETERS
//  ADDR_WIDTH   10  PC / instruction address width
//  STACK_DEPTH  16  return-stack entries; power of 2, >=2
//  RESET_PC     0   PC value after reset
// PORTS
//  Clock           in   1           rising-edge clock
//  Reset           in   1           reset, synchronous, active-high
//  Stall           in   1           freeze PC, stack, state this cycle
//  Resume          in   1           single-cycle pulse; leaves normal HALT
//  Halt            in   1           decoded HALT
//  Jump            in   1           decoded JAL/JR
//  Branch          in   1           decoded conditional branch
//  Branch_Cond     in   1           ALU compare result (1 = taken)
//  Stack_Enable    in   1           stack op requested
//  Stack_Write     in   1           1 = push (JAL), 0 = pop (RET)
//  Jump_Addr       in   ADDR_WIDTH  jump target (imm or reg, muxed upstream)
//  Branch_Addr     in   ADDR_WIDTH  branch target
//  PC              out  ADDR_WIDTH  current instruction address
//  Halted          out  1           1 in HALT or FAULT
//  Fault           out  1           1 in FAULT
//  Stack_Overflow  out  1           sticky: push attempted when full
//  Stack_Underflow out  1           sticky: pop attempted when empty
//  Stack_Count     out  log2(DEPTH)+1  current entries
// BEHAVIOUR
//  Reset (every output): PC=RESET_PC, state=RUN, Halted=0, Fault=0, flags=0, Stack_Count=0.
//   Stack RAM contents not cleared. Reset mid-operation (incl. FAULT) wins over everything.
//  States: RUN, HALT, FAULT. All updates 1 cycle after inputs sampled; PC registered.
//  RUN, priority (first match wins):
//   1 Stall=1: hold all.
//   2 Halt=1: PC holds, -> HALT.
//   3 Stack_Enable & Stack_Write (JAL): full -> Stack_Overflow=1, PC holds, -> FAULT;
//     else push PC+1, PC<=Jump_Addr, count+1.
//   4 Stack_Enable & !Stack_Write (RET): empty -> Stack_Underflow=1, PC holds, -> FAULT;
//     else PC<=top, count-1.
//   5 Jump (JR): PC<=Jump_Addr.
//   6 Branch & Branch_Cond: PC<=Branch_Addr.   Branch & !Branch_Cond: PC<=PC+1.
//   7 else PC<=PC+1.
//  HALT: PC holds; Resume=1 -> PC<=PC+1, RUN (Stall ignored in HALT). Resume in RUN ignored.
//  FAULT: PC, stack frozen; exits only by Reset; Resume ignored.
//  Arithmetic: PC+1 modulo 2^ADDR_WIDTH (max wraps to 0); pushed value also wraps.
//  Stack: full when count==STACK_DEPTH, empty when count==0; push then pop returns same
//   value; one stack op per cycle max.
//  Halted = (state!=RUN); Fault = (state==FAULT); combinational from state register.
// STRUCTURE
//  Package pc_stack_pkg: state encoding localparams (RUN=2'd0, HALT=2'd1, FAULT=2'd2),
//   default ADDR_WIDTH/STACK_DEPTH constants.
//  Sub-module return_stack: LIFO RAM + pointer, push/pop/full/empty/count, sync reset of pointer.
//  Top: state FSM, next-PC mux, flag registers.
// TESTING
//  Reset, 4 cycles no controls -> PC 0,1,2,3; Halted=0.
//  JAL Jump_Addr=0x40 at PC=5, then RET at 0x40 -> PC 0x40 then 6; Stack_Count 1 then 0.
//  17 nested JALs, DEPTH=16 -> 17th: Stack_Overflow=1, Fault=1, PC frozen; Resume no effect; Reset clears.
//  RET with empty stack at PC=3 -> Stack_Underflow=1, Fault=1, PC stays 3.
//  Halt at PC=9 -> PC holds 9, Halted=1; Resume pulse -> PC=10, Halted=0.
//  PC=0x3FF, no control -> PC=0; Branch Cond=1 Addr=0x20 with Stall=1 -> PC holds, then 0x20 after release.

Source files
------------

// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program-counter / return-stack slice:
// the FSM state encoding and the default geometry constants.
package pc_stack_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 10;
  localparam int unsigned DEF_STACK_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_stack_unit_if.sv
// Decoder-side controls and PC-stage status bundled into one interface.
// The master drives controls and observes status; the slave is the PC stage.
interface pc_stack_unit_if import pc_stack_pkg::*; #(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
);
  localparam int unsigned CW = $clog2(STACK_DEPTH) + 1;

  logic                  Stall;
  logic                  Resume;
  logic                  Halt;
  logic                  Jump;
  logic                  Branch;
  logic                  Branch_Cond;
  logic                  Stack_Enable;
  logic                  Stack_Write;
  logic [ADDR_WIDTH-1:0] Jump_Addr;
  logic [ADDR_WIDTH-1:0] Branch_Addr;
  logic [ADDR_WIDTH-1:0] PC;
  logic                  Halted;
  logic                  Fault;
  logic                  Stack_Overflow;
  logic                  Stack_Underflow;
  logic [CW-1:0]         Stack_Count;

  modport master (
    output Stall, Resume, Halt, Jump, Branch, Branch_Cond,
           Stack_Enable, Stack_Write, Jump_Addr, Branch_Addr,
    input  PC, Halted, Fault, Stack_Overflow, Stack_Underflow, Stack_Count
  );

  modport slave (
    input  Stall, Resume, Halt, Jump, Branch, Branch_Cond,
           Stack_Enable, Stack_Write, Jump_Addr, Branch_Addr,
    output PC, Halted, Fault, Stack_Overflow, Stack_Underflow, Stack_Count
  );

endinterface

// File: rtl/return_stack.sv
// LIFO return-address store: RAM plus an entry counter that doubles as the
// write pointer. Only the counter is reset; RAM contents survive reset.
module return_stack #(
  parameter  int unsigned WIDTH = 10,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;

  assign w_wr_idx = r_count[AW-1:0];
  assign w_rd_idx = w_wr_idx - AW'(1);
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_top    = r_mem[w_rd_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_count <= r_count + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program-counter stage: RUN/HALT/FAULT state machine, next-PC selection
// and sticky stack-error flags around the return-address stack.
module pc_stack_unit import pc_stack_pkg::*; #(
  parameter int unsigned          ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned          STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic            Clock,
  input  logic            Reset,
  pc_stack_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(STACK_DEPTH) + 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  w_set_ovf;
  logic                  w_set_unf;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [ADDR_WIDTH-1:0] w_top;
  logic [CW-1:0]         w_count;

  assign w_pc_inc = r_pc + ADDR_WIDTH'(1);

  return_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    case (r_state)
      ST_RUN: begin
        // Branch on priority: stall freezes everything, HALT beats stack ops.
        if (bus.Stall) begin
          w_state_nxt = ST_RUN;
        end else if (bus.Halt) begin
          w_state_nxt = ST_HALT;
        end else if (bus.Stack_Enable && bus.Stack_Write) begin
          if (w_full) begin
            w_set_ovf   = 1'b1;
            w_state_nxt = ST_FAULT;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = bus.Jump_Addr;
          end
        end else if (bus.Stack_Enable) begin
          if (w_empty) begin
            w_set_unf   = 1'b1;
            w_state_nxt = ST_FAULT;
          end else begin
            w_pop    = 1'b1;
            w_pc_nxt = w_top;
          end
        end else if (bus.Jump) begin
          w_pc_nxt = bus.Jump_Addr;
        end else if (bus.Branch && bus.Branch_Cond) begin
          w_pc_nxt = bus.Branch_Addr;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      ST_HALT: begin
        if (bus.Resume) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_RUN;
        end
      end
      ST_FAULT: w_state_nxt = ST_FAULT;
      default:  w_state_nxt = ST_FAULT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ovf   <= r_ovf | w_set_ovf;
      r_unf   <= r_unf | w_set_unf;
    end
  end

  assign bus.PC              = r_pc;
  assign bus.Halted          = (r_state != ST_RUN);
  assign bus.Fault           = (r_state == ST_FAULT);
  assign bus.Stack_Overflow  = r_ovf;
  assign bus.Stack_Underflow = r_unf;
  assign bus.Stack_Count     = w_count;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: sequencing, JAL/RET, HALT/Resume,
// stall, wrap-around, overflow/underflow faults and reset recovery.
module tb_pc_stack_unit;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pc_stack_unit_if #(.ADDR_WIDTH(10), .STACK_DEPTH(16)) bus ();

  pc_stack_unit #(
    .ADDR_WIDTH  (10),
    .STACK_DEPTH (16),
    .RESET_PC    (10'd0)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    bus.Stall = 0; bus.Resume = 0; bus.Halt = 0; bus.Jump = 0;
    bus.Branch = 0; bus.Branch_Cond = 0; bus.Stack_Enable = 0;
    bus.Stack_Write = 0; bus.Jump_Addr = '0; bus.Branch_Addr = '0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    clear_ctl();
  endtask

  task automatic jal(input logic [9:0] tgt);
    bus.Stack_Enable = 1; bus.Stack_Write = 1; bus.Jump_Addr = tgt;
    step();
  endtask

  task automatic ret();
    bus.Stack_Enable = 1; bus.Stack_Write = 0;
    step();
  endtask

  task automatic do_reset();
    Reset = 1;
    step();
    Reset = 0;
  endtask

  initial begin
    clear_ctl();
    Reset = 1;
    step();
    step();
    Reset = 0;
    chk("rst_pc", bus.PC, 0);
    chk("rst_halted", bus.Halted, 0);
    chk("rst_fault", bus.Fault, 0);
    chk("rst_ovf", bus.Stack_Overflow, 0);
    chk("rst_unf", bus.Stack_Underflow, 0);
    chk("rst_count", bus.Stack_Count, 0);

    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", bus.PC, i);
    end
    chk("seq_halted", bus.Halted, 0);

    jal(10'h040);
    chk("jal_pc", bus.PC, 32'h40);
    chk("jal_count", bus.Stack_Count, 1);
    ret();
    chk("ret_pc", bus.PC, 6);
    chk("ret_count", bus.Stack_Count, 0);

    step(); step(); step();
    chk("pre_halt_pc", bus.PC, 9);
    bus.Halt = 1;
    step();
    chk("halt_pc", bus.PC, 9);
    chk("halt_halted", bus.Halted, 1);
    chk("halt_fault", bus.Fault, 0);
    bus.Stall = 1;
    step();
    chk("halt_hold_pc", bus.PC, 9);
    bus.Resume = 1; bus.Stall = 1;
    step();
    chk("resume_pc", bus.PC, 10);
    chk("resume_halted", bus.Halted, 0);
    bus.Resume = 1;
    step();
    chk("resume_run_pc", bus.PC, 11);

    bus.Stall = 1; bus.Stack_Enable = 1; bus.Stack_Write = 1; bus.Jump_Addr = 10'h055;
    step();
    chk("stall_jal_pc", bus.PC, 11);
    chk("stall_jal_count", bus.Stack_Count, 0);
    bus.Stall = 1; bus.Branch = 1; bus.Branch_Cond = 1; bus.Branch_Addr = 10'h020;
    step();
    chk("stall_br_pc", bus.PC, 11);
    bus.Branch = 1; bus.Branch_Cond = 1; bus.Branch_Addr = 10'h020;
    step();
    chk("br_taken_pc", bus.PC, 32'h20);
    bus.Branch = 1; bus.Branch_Cond = 0; bus.Branch_Addr = 10'h080;
    step();
    chk("br_nt_pc", bus.PC, 32'h21);

    bus.Jump = 1; bus.Jump_Addr = 10'h3FF;
    step();
    chk("jr_pc", bus.PC, 32'h3FF);
    jal(10'h010);
    chk("jal_wrap_pc", bus.PC, 32'h10);
    ret();
    chk("ret_wrap_pc", bus.PC, 0);
    bus.Jump = 1; bus.Jump_Addr = 10'h3FF;
    step();
    step();
    chk("pc_wrap", bus.PC, 0);

    bus.Halt = 1; bus.Stack_Enable = 1; bus.Stack_Write = 1; bus.Jump_Addr = 10'h077;
    step();
    chk("halt_prio_pc", bus.PC, 0);
    chk("halt_prio_count", bus.Stack_Count, 0);
    chk("halt_prio_halted", bus.Halted, 1);
    bus.Resume = 1;
    step();
    chk("halt_prio_resume", bus.PC, 1);

    bus.Stack_Enable = 1; bus.Stack_Write = 1; bus.Jump = 1; bus.Branch = 1;
    bus.Branch_Cond = 1; bus.Jump_Addr = 10'h030; bus.Branch_Addr = 10'h031;
    step();
    chk("jal_prio_pc", bus.PC, 32'h30);
    bus.Stack_Enable = 1; bus.Jump = 1; bus.Jump_Addr = 10'h099;
    step();
    chk("ret_prio_pc", bus.PC, 2);
    chk("ret_prio_count", bus.Stack_Count, 0);

    do_reset();
    chk("lifo_start", bus.PC, 0);
    jal(10'h050);
    jal(10'h060);
    chk("lifo_count2", bus.Stack_Count, 2);
    ret();
    chk("lifo_ret1", bus.PC, 32'h51);
    ret();
    chk("lifo_ret2", bus.PC, 1);

    do_reset();
    for (int i = 0; i < 16; i++) jal(10'(32'h100 + i));
    chk("full_count", bus.Stack_Count, 16);
    chk("full_pc", bus.PC, 32'h10F);
    chk("full_ovf", bus.Stack_Overflow, 0);
    chk("full_fault", bus.Fault, 0);
    jal(10'h200);
    chk("ovf_pc", bus.PC, 32'h10F);
    chk("ovf_flag", bus.Stack_Overflow, 1);
    chk("ovf_fault", bus.Fault, 1);
    chk("ovf_halted", bus.Halted, 1);
    chk("ovf_count", bus.Stack_Count, 16);
    bus.Resume = 1;
    step();
    chk("ovf_resume_pc", bus.PC, 32'h10F);
    chk("ovf_resume_fault", bus.Fault, 1);
    ret();
    chk("ovf_ret_pc", bus.PC, 32'h10F);
    chk("ovf_ret_count", bus.Stack_Count, 16);
    do_reset();
    chk("ovf_rst_pc", bus.PC, 0);
    chk("ovf_rst_fault", bus.Fault, 0);
    chk("ovf_rst_flag", bus.Stack_Overflow, 0);
    chk("ovf_rst_count", bus.Stack_Count, 0);
    chk("ovf_rst_halted", bus.Halted, 0);

    step(); step(); step();
    chk("unf_pre_pc", bus.PC, 3);
    ret();
    chk("unf_pc", bus.PC, 3);
    chk("unf_flag", bus.Stack_Underflow, 1);
    chk("unf_fault", bus.Fault, 1);
    chk("unf_ovf", bus.Stack_Overflow, 0);
    chk("unf_count", bus.Stack_Count, 0);
    step();
    chk("unf_frozen_pc", bus.PC, 3);
    do_reset();
    chk("unf_rst_flag", bus.Stack_Underflow, 0);
    chk("unf_rst_fault", bus.Fault, 0);
    step();
    chk("unf_rst_run", bus.PC, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
